// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Instruction fetch stage. It issues one instruction-memory read at a time
//   and buffers the returned word for decode. It also handles PC redirects
//   (taken branches and jumps) and stops fetching after a halting ecall.
//
// Ports:
//   clk            - single clock; all state changes on its rising edge
//   reset          - synchronous, active-high reset
//   imem_req       - read request, held until imem_ready
//   imem_addr      - fetch address, stable while imem_req=1
//   imem_ready     - one-cycle pulse: imem_rdata is valid for the request
//   imem_rdata     - instruction word returned by memory
//   inst_valid     - inst / inst_pc hold an instruction for decode
//   inst_ready     - decode accepts the buffered instruction this cycle
//   inst           - buffered instruction word
//   inst_pc        - address of inst
//   part_of_inst   - inst[6:0], the opcode field for the control unit
//   redirect_valid - request a PC change
//   redirect_pc    - redirect target (the low two bits are ignored)
//   halt           - the instruction being accepted is a halting ecall
//   is_halted      - fetch is stopped until reset
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  part_of_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        is_halted
);

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  // pc_reg is the architectural next-fetch PC. addr_reg is the address of
  // the request currently on the bus. They differ only while a redirect has
  // arrived during an outstanding request (kill_reg=1): the bus address has
  // to stay stable until memory answers.
  logic [31:0] pc_reg, pc_next;
  logic [31:0] addr_reg, addr_next;
  logic        kill_reg, kill_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] inst_pc_reg, inst_pc_next;

  logic [31:0] redirect_aligned;
  logic [31:0] pc_plus4;

  assign redirect_aligned = redirect_pc & ~32'h3;
  assign pc_plus4         = pc_reg + 32'd4;  // wraps 32'hFFFF_FFFC -> 0

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_REQ;
      pc_reg      <= RESET_PC;
      addr_reg    <= RESET_PC;
      kill_reg    <= 1'b0;
      inst_reg    <= 32'd0;
      inst_pc_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      addr_reg    <= addr_next;
      kill_reg    <= kill_next;
      inst_reg    <= inst_next;
      inst_pc_reg <= inst_pc_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    addr_next    = addr_reg;
    kill_next    = kill_reg;
    inst_next    = inst_reg;
    inst_pc_next = inst_pc_reg;

    case (state_reg)
      ST_REQ: begin
        if (imem_ready) begin
          if (kill_reg || redirect_valid) begin
            // The response belongs to a stale path. Drop it and request
            // the latest target on the next cycle.
            if (redirect_valid) begin
              pc_next   = redirect_aligned;
              addr_next = redirect_aligned;
            end else begin
              addr_next = pc_reg;
            end
            kill_next = 1'b0;
          end else begin
            inst_next    = imem_rdata;
            inst_pc_next = addr_reg;
            state_next   = ST_HOLD;
          end
        end else if (redirect_valid) begin
          // A later redirect simply overwrites pc_reg, so only the last
          // target is fetched.
          pc_next   = redirect_aligned;
          kill_next = 1'b1;
        end
      end

      ST_HOLD: begin
        // halt applies only to an accepted instruction and beats a
        // simultaneous redirect.
        if (inst_ready && halt) begin
          state_next = ST_HALTED;
        end else if (redirect_valid) begin
          pc_next    = redirect_aligned;
          addr_next  = redirect_aligned;
          state_next = ST_REQ;
        end else if (inst_ready) begin
          pc_next    = pc_plus4;
          addr_next  = pc_plus4;
          state_next = ST_REQ;
        end
      end

      ST_HALTED: begin
        state_next = ST_HALTED;
      end

      default: begin
        state_next = ST_REQ;
      end
    endcase
  end

  // The handshake outputs are gated by reset so that no request or
  // instruction is presented during the reset cycle.
  assign imem_req     = (state_reg == ST_REQ) && !reset;
  assign inst_valid   = (state_reg == ST_HOLD) && !reset;
  assign is_halted    = (state_reg == ST_HALTED);
  assign imem_addr    = addr_reg;
  assign inst         = inst_reg;
  assign inst_pc      = inst_pc_reg;
  assign part_of_inst = inst_reg[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural instruction memory
// answers each request after a programmable delay. Every fetch the bench
// expects is pushed onto a scoreboard queue, and each acceptance by the
// decode side pops the queue and compares the result. A table of redirect
// vectors covers alignment and PC wrap. Hand-written sequences cover the
// multi-cycle cases: stall, kill, double redirect, coincident redirect and
// halt.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  part_of_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        is_halted;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_delay = 2;
  int mem_cnt   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] target;
    int          delay;
    int          n_follow;
  } vec_t;
  vec_t vecs[4];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .part_of_inst   (part_of_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .is_halted      (is_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_A5A5) * 32'h9E37_79B1 + 32'h13;
  endfunction

  // Memory model: it decides 2 time units after each rising edge, once the
  // DUT outputs have settled. The response arrives in the mem_delay-th
  // cycle of a request.
  always @(posedge clk) begin
    #2;
    if (reset || !imem_req) begin
      imem_ready = 1'b0;
      mem_cnt    = 0;
    end else begin
      mem_cnt++;
      if (mem_cnt >= mem_delay) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_cnt    = 0;
      end else begin
        imem_ready = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = mem_word(pc);
    sb.push_back(e);
  endtask

  // Starts at a negedge. Waits for the memory response, then checks that
  // inst_valid rises one cycle later.
  task automatic wait_inst();
    int i;
    for (i = 0; i < 50; i++) begin
      if (imem_ready) break;
      @(negedge clk);
    end
    if (i == 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ready: got no imem_ready within 50 cycles, required a response");
    end
    @(negedge clk);
    chk("ready_to_valid", inst_valid, 1);
  endtask

  // Starts at a negedge with an instruction buffered. Compares it against
  // the scoreboard and accepts it, optionally with a redirect and/or halt.
  task automatic accept(input bit rd, input logic [31:0] rd_pc, input bit hl,
                        input bit chk_next, input logic [31:0] next_addr);
    exp_t e;
    chk("acc_valid", inst_valid, 1);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL acc_sb: got inst_pc %h, required nothing pending", inst_pc);
    end else begin
      e = sb.pop_front();
      chk("acc_pc", inst_pc, e.pc);
      chk("acc_inst", inst, e.word);
      chk("acc_opcode", {25'd0, part_of_inst}, {25'd0, e.word[6:0]});
    end
    $display("accept pc=%h inst=%h redirect=%0d halt=%0d", inst_pc, inst, rd, hl);
    inst_ready     = 1'b1;
    redirect_valid = rd;
    redirect_pc    = rd_pc;
    halt           = hl;
    @(negedge clk);
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    if (chk_next) begin
      chk("next_req", imem_req, 1);
      chk("next_addr", imem_addr, next_addr);
      chk("next_valid_low", inst_valid, 0);
    end
  endtask

  // Starts at a negedge during a killed request. Waits for the stale
  // response, then checks that the new request targets tgt.
  task automatic wait_discard(input logic [31:0] tgt);
    int i;
    for (i = 0; i < 50; i++) begin
      if (imem_ready) break;
      chk("kill_valid_low", inst_valid, 0);
      @(negedge clk);
    end
    if (i == 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_discard: got no imem_ready within 50 cycles, required a response");
    end
    @(negedge clk);
    chk("discard_valid_low", inst_valid, 0);
    chk("discard_req", imem_req, 1);
    chk("discard_addr", imem_addr, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    int i;

    vecs[0] = '{target: 32'h0000_0103, delay: 2, n_follow: 2};
    vecs[1] = '{target: 32'hFFFF_FFFC, delay: 1, n_follow: 2};
    vecs[2] = '{target: 32'hFFFF_FFFA, delay: 3, n_follow: 3};
    vecs[3] = '{target: 32'h0000_000B, delay: 2, n_follow: 1};

    reset          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt           = 1'b0;
    imem_ready     = 1'b0;
    imem_rdata     = 32'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_halted", is_halted, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    reset = 1'b0;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);

    // Sequential fetch 0x0, 0x4, 0x8.
    mem_delay = 2;
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    @(negedge clk);
    wait_inst();
    accept(0, 32'h0, 0, 1, 32'h4);
    wait_inst();
    accept(0, 32'h0, 0, 1, 32'h8);
    wait_inst();

    // Decode stalls for 5 cycles: the buffer holds and no request is made.
    for (i = 0; i < 5; i++) begin
      chk("stall_valid", inst_valid, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_pc", inst_pc, sb[0].pc);
      chk("stall_inst", inst, sb[0].word);
      @(negedge clk);
    end

    // Redirect table: accept with redirect, then follow the new path.
    foreach (vecs[v]) begin
      tgt = vecs[v].target & ~32'h3;
      mem_delay = vecs[v].delay;
      accept(1, vecs[v].target, 0, 1, tgt);
      for (int k = 0; k < vecs[v].n_follow; k++) push_exp(tgt + 32'(4 * k));
      for (int k = 0; k < vecs[v].n_follow; k++) begin
        wait_inst();
        if (k < vecs[v].n_follow - 1) accept(0, 32'h0, 0, 1, tgt + 32'(4 * (k + 1)));
      end
    end

    // Redirect during an outstanding request at 0xC.
    mem_delay = 4;
    accept(0, 32'h0, 0, 1, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("kill_addr_held", imem_addr, 32'hC);
    chk("kill_req_held", imem_req, 1);
    wait_discard(32'h200);
    push_exp(32'h200);
    wait_inst();

    // Two redirects while the kill flag is set: the last target wins.
    mem_delay = 5;
    accept(0, 32'h0, 0, 1, 32'h204);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_pc    = 32'h406;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("dbl_addr_held", imem_addr, 32'h204);
    wait_discard(32'h404);
    push_exp(32'h404);
    wait_inst();

    // Redirect coinciding with the memory response.
    mem_delay = 3;
    accept(0, 32'h0, 0, 1, 32'h408);
    for (i = 0; i < 50; i++) begin
      if (imem_ready) break;
      @(negedge clk);
    end
    chk("coinc_ready_seen", imem_ready, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("coinc_valid_low", inst_valid, 0);
    chk("coinc_req", imem_req, 1);
    chk("coinc_addr", imem_addr, 32'h500);
    push_exp(32'h500);
    wait_inst();

    // Halt beats a simultaneous redirect. Inputs are then ignored.
    accept(1, 32'h600, 1, 0, 32'h0);
    chk("halt_is_halted", is_halted, 1);
    chk("halt_req", imem_req, 0);
    chk("halt_valid", inst_valid, 0);
    for (i = 0; i < 20; i++) begin
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc    = $urandom;
      inst_ready     = 1'($urandom_range(0, 1));
      halt           = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halted_stay", is_halted, 1);
      chk("halted_req", imem_req, 0);
      chk("halted_valid", inst_valid, 0);
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    halt           = 1'b0;

    // Reset restarts fetch at RESET_PC.
    reset = 1'b1;
    @(negedge clk);
    chk("rerst_req", imem_req, 0);
    chk("rerst_halted", is_halted, 0);
    reset = 1'b0;
    #1;
    chk("rerst_first_req", imem_req, 1);
    chk("rerst_first_addr", imem_addr, 32'h0);
    sb.delete();
    mem_delay = 2;
    push_exp(32'h0);
    @(negedge clk);
    wait_inst();
    accept(0, 32'h0, 0, 1, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
